decode_cycle: RTL and testbench

- Second pipeline stage: consumes the fetched instruction word and PC from the IF/ID register and produces a registered ID/EX bundle for the execute stage.
- Contains the integer register file, main and ALU control decode, and the immediate generator.
- Accepts the writeback port from the final stage.
- Honors a flush from execute: when a taken branch or jump redirects fetch, the instruction entering execute is squashed.

---
 rtl/decode_cycle.sv | 225 ++++++++++++++++++++++
 tb/tb_decode_cycle.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_cycle.sv
// Decode stage: register file with write-first bypass, main/ALU control decode,
// immediate generation, and the ID/EX pipeline register with flush support.
module decode_cycle #(
    parameter int unsigned     XLEN      = 32,
    parameter int unsigned     REG_COUNT = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     instr_d,
    input  logic [XLEN-1:0] pc_d,
    input  logic            flush_e,
    input  logic            reg_write_w,
    input  logic [4:0]      rd_w,
    input  logic [XLEN-1:0] result_w,
    output logic            reg_write_e,
    output logic [1:0]      result_src_e,
    output logic            mem_write_e,
    output logic            jump_e,
    output logic            branch_e,
    output logic [2:0]      alu_control_e,
    output logic            alu_src_e,
    output logic [XLEN-1:0] rd1_e,
    output logic [XLEN-1:0] rd2_e,
    output logic [XLEN-1:0] imm_ext_e,
    output logic [4:0]      rs1_e,
    output logic [4:0]      rs2_e,
    output logic [4:0]      rd_e,
    output logic [XLEN-1:0] pc_e,
    output logic [XLEN-1:0] pc_plus4_e
);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;

    assign opcode   = instr_d[6:0];
    assign funct3   = instr_d[14:12];
    assign funct7b5 = instr_d[30];
    assign rs1      = instr_d[19:15];
    assign rs2      = instr_d[24:20];
    assign rd       = instr_d[11:7];

    logic [XLEN-1:0] regs [REG_COUNT];

    // x0 is never written, so it stays at its reset value of zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else if (reg_write_w && (rd_w != 5'd0)) begin
            regs[rd_w] <= result_w;
        end
    end

    // Write-first bypass avoids needing a half-cycle register-file write
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;

    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (rs1 != 5'd0) begin
            rd1 = (reg_write_w && (rd_w == rs1)) ? result_w : regs[rs1];
        end
        if (rs2 != 5'd0) begin
            rd2 = (reg_write_w && (rd_w == rs2)) ? result_w : regs[rs2];
        end
    end

    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_j;

    assign imm_i = {{(XLEN-12){instr_d[31]}}, instr_d[31:20]};
    assign imm_s = {{(XLEN-12){instr_d[31]}}, instr_d[31:25], instr_d[11:7]};
    assign imm_b = {{(XLEN-13){instr_d[31]}}, instr_d[31], instr_d[7],
                    instr_d[30:25], instr_d[11:8], 1'b0};
    assign imm_j = {{(XLEN-21){instr_d[31]}}, instr_d[31], instr_d[19:12],
                    instr_d[20], instr_d[30:21], 1'b0};

    logic            reg_write;
    logic [1:0]      result_src;
    logic            mem_write;
    logic            jump;
    logic            branch;
    logic            alu_src;
    logic [1:0]      alu_op;
    logic [2:0]      alu_control;
    logic [XLEN-1:0] imm_ext;

    // Main decode; unknown opcodes become a bubble but fields still pass through
    always_comb begin
        reg_write  = 1'b0;
        result_src = 2'b00;
        mem_write  = 1'b0;
        jump       = 1'b0;
        branch     = 1'b0;
        alu_src    = 1'b0;
        alu_op     = 2'b00;
        imm_ext    = imm_i;
        case (opcode)
            OP_LW: begin
                reg_write  = 1'b1;
                alu_src    = 1'b1;
                result_src = 2'b01;
            end
            OP_SW: begin
                mem_write = 1'b1;
                alu_src   = 1'b1;
                imm_ext   = imm_s;
            end
            OP_R: begin
                reg_write = 1'b1;
                alu_op    = 2'b10;
            end
            OP_I: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                alu_op    = 2'b10;
            end
            OP_BEQ: begin
                branch  = 1'b1;
                alu_op  = 2'b01;
                imm_ext = imm_b;
            end
            OP_JAL: begin
                reg_write  = 1'b1;
                jump       = 1'b1;
                result_src = 2'b10;
                imm_ext    = imm_j;
            end
            default: ;
        endcase
    end

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            2'b01: alu_control = ALU_SUB;
            2'b10: begin
                case (funct3)
                    3'b000:  alu_control = ((opcode == OP_R) && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

    // ID/EX register; a flush loads an all-zero bubble
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_write_e   <= 1'b0;
            result_src_e  <= 2'b00;
            mem_write_e   <= 1'b0;
            jump_e        <= 1'b0;
            branch_e      <= 1'b0;
            alu_control_e <= 3'b000;
            alu_src_e     <= 1'b0;
            rd1_e         <= '0;
            rd2_e         <= '0;
            imm_ext_e     <= '0;
            rs1_e         <= 5'd0;
            rs2_e         <= 5'd0;
            rd_e          <= 5'd0;
            pc_e          <= RESET_PC;
            pc_plus4_e    <= RESET_PC + XLEN'(4);
        end else if (flush_e) begin
            reg_write_e   <= 1'b0;
            result_src_e  <= 2'b00;
            mem_write_e   <= 1'b0;
            jump_e        <= 1'b0;
            branch_e      <= 1'b0;
            alu_control_e <= 3'b000;
            alu_src_e     <= 1'b0;
            rd1_e         <= '0;
            rd2_e         <= '0;
            imm_ext_e     <= '0;
            rs1_e         <= 5'd0;
            rs2_e         <= 5'd0;
            rd_e          <= 5'd0;
            pc_e          <= '0;
            pc_plus4_e    <= '0;
        end else begin
            reg_write_e   <= reg_write;
            result_src_e  <= result_src;
            mem_write_e   <= mem_write;
            jump_e        <= jump;
            branch_e      <= branch;
            alu_control_e <= alu_control;
            alu_src_e     <= alu_src;
            rd1_e         <= rd1;
            rd2_e         <= rd2;
            imm_ext_e     <= imm_ext;
            rs1_e         <= rs1;
            rs2_e         <= rs2;
            rd_e          <= rd;
            pc_e          <= pc_d;
            pc_plus4_e    <= pc_d + XLEN'(4);
        end
    end

endmodule

// File: tb/tb_decode_cycle.sv
// Bench for decode_cycle: directed vector table, reset/flush sequences,
// then randomized instructions checked against a behavioural model.
module tb_decode_cycle;

    typedef struct packed {
        logic        reg_write;
        logic [1:0]  result_src;
        logic        mem_write;
        logic        jump;
        logic        branch;
        logic [2:0]  alu_control;
        logic        alu_src;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] pc4;
    } out_t;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        flush;
        logic        we;
        logic [4:0]  rdw;
        logic [31:0] resw;
        out_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic        flush_e;
    logic        reg_write_w;
    logic [4:0]  rd_w;
    logic [31:0] result_w;
    logic        reg_write_e;
    logic [1:0]  result_src_e;
    logic        mem_write_e;
    logic        jump_e;
    logic        branch_e;
    logic [2:0]  alu_control_e;
    logic        alu_src_e;
    logic [31:0] rd1_e;
    logic [31:0] rd2_e;
    logic [31:0] imm_ext_e;
    logic [4:0]  rs1_e;
    logic [4:0]  rs2_e;
    logic [4:0]  rd_e;
    logic [31:0] pc_e;
    logic [31:0] pc_plus4_e;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mregs [32];

    out_t act;
    assign act = {reg_write_e, result_src_e, mem_write_e, jump_e, branch_e,
                  alu_control_e, alu_src_e, rd1_e, rd2_e, imm_ext_e,
                  rs1_e, rs2_e, rd_e, pc_e, pc_plus4_e};

    decode_cycle dut (
        .clk           (clk),
        .rst           (rst),
        .instr_d       (instr_d),
        .pc_d          (pc_d),
        .flush_e       (flush_e),
        .reg_write_w   (reg_write_w),
        .rd_w          (rd_w),
        .result_w      (result_w),
        .reg_write_e   (reg_write_e),
        .result_src_e  (result_src_e),
        .mem_write_e   (mem_write_e),
        .jump_e        (jump_e),
        .branch_e      (branch_e),
        .alu_control_e (alu_control_e),
        .alu_src_e     (alu_src_e),
        .rd1_e         (rd1_e),
        .rd2_e         (rd2_e),
        .imm_ext_e     (imm_ext_e),
        .rs1_e         (rs1_e),
        .rs2_e         (rs2_e),
        .rd_e          (rd_e),
        .pc_e          (pc_e),
        .pc_plus4_e    (pc_plus4_e)
    );

    always #5 clk = ~clk;

    function automatic out_t mk(input logic rw, input logic [1:0] rs, input logic mw,
                                input logic j, input logic b, input logic [2:0] alu,
                                input logic asrc, input logic [31:0] r1, input logic [31:0] r2,
                                input logic [31:0] imm, input logic [4:0] i1, input logic [4:0] i2,
                                input logic [4:0] id, input logic [31:0] pc, input logic [31:0] pc4);
        out_t o;
        o = '{reg_write: rw, result_src: rs, mem_write: mw, jump: j, branch: b,
              alu_control: alu, alu_src: asrc, rd1: r1, rd2: r2, imm: imm,
              rs1: i1, rs2: i2, rd: id, pc: pc, pc4: pc4};
        return o;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] idx, input logic we,
                                               input logic [4:0] rdw, input logic [31:0] resw);
        if (idx == 5'd0) return 32'd0;
        if (we && rdw == idx) return resw;
        return mregs[idx];
    endfunction

    // Behavioural reference built from the instruction-set rules
    function automatic out_t model(input logic [31:0] ins, input logic [31:0] pc, input logic flush,
                                   input logic we, input logic [4:0] rdw, input logic [31:0] resw);
        out_t o;
        int   sins;
        int   imm;
        logic [6:0] op;
        logic [2:0] f3;
        o = '0;
        if (flush) return o;
        sins = int'(ins);
        op   = ins[6:0];
        f3   = ins[14:12];
        o.rs1 = ins[19:15];
        o.rs2 = ins[24:20];
        o.rd  = ins[11:7];
        o.rd1 = model_read(o.rs1, we, rdw, resw);
        o.rd2 = model_read(o.rs2, we, rdw, resw);
        o.pc  = pc;
        o.pc4 = pc + 32'd4;
        imm = sins >>> 20;
        if (op == 7'h23) imm = ((sins >>> 25) * 32) + int'(ins[11:7]);
        if (op == 7'h63) imm = ((sins >>> 31) * 4096) + int'(ins[7]) * 2048
                               + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
        if (op == 7'h6F) imm = ((sins >>> 31) * 1048576) + int'(ins[19:12]) * 4096
                               + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
        o.imm = 32'(imm);
        o.reg_write  = (op == 7'h03) || (op == 7'h33) || (op == 7'h13) || (op == 7'h6F);
        o.alu_src    = (op == 7'h03) || (op == 7'h23) || (op == 7'h13);
        o.mem_write  = (op == 7'h23);
        o.branch     = (op == 7'h63);
        o.jump       = (op == 7'h6F);
        o.result_src = (op == 7'h03) ? 2'b01 : (op == 7'h6F) ? 2'b10 : 2'b00;
        o.alu_control = 3'b000;
        if (op == 7'h63) begin
            o.alu_control = 3'b001;
        end else if (op == 7'h33 || op == 7'h13) begin
            if (f3 == 3'd0 && op == 7'h33 && ins[30]) o.alu_control = 3'b001;
            else if (f3 == 3'd2) o.alu_control = 3'b101;
            else if (f3 == 3'd6) o.alu_control = 3'b011;
            else if (f3 == 3'd7) o.alu_control = 3'b010;
        end
        return o;
    endfunction

    task automatic check(input string name, input out_t got, input out_t want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Drive one cycle of inputs, update model registers, sample after the edge
    task automatic apply(input logic [31:0] ins, input logic [31:0] pc, input logic flush,
                         input logic we, input logic [4:0] rdw, input logic [31:0] resw,
                         output out_t want);
        instr_d     = ins;
        pc_d        = pc;
        flush_e     = flush;
        reg_write_w = we;
        rd_w        = rdw;
        result_w    = resw;
        want = model(ins, pc, flush, we, rdw, resw);
        if (we && rdw != 5'd0) mregs[rdw] = resw;
        @(posedge clk);
        #1;
    endtask

    vec_t  tbl[$];
    out_t  want;
    out_t  rst_val;
    logic [6:0] ops [7];

    initial begin
        rst_val = '0;
        rst_val.pc4 = 32'd4;
        foreach (mregs[i]) mregs[i] = 32'd0;

        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            instr_d = $urandom; pc_d = $urandom; flush_e = 1'($urandom);
            reg_write_w = 1'($urandom); rd_w = 5'($urandom); result_w = $urandom;
            @(posedge clk);
            #1;
        end
        check("reset_hold", act, rst_val);
        rst = 1'b1;

        tbl.push_back('{"addi", 32'h00500093, 32'h10, 1'b0, 1'b0, 5'd0, 32'd0,
            mk(1, 2'b00, 0, 0, 0, 3'b000, 1, 0, 0, 5, 0, 5, 1, 32'h10, 32'h14)});
        tbl.push_back('{"lw_bypass", 32'h0080A103, 32'h14, 1'b0, 1'b1, 5'd1, 32'h1234,
            mk(1, 2'b01, 0, 0, 0, 3'b000, 1, 32'h1234, 0, 8, 1, 8, 2, 32'h14, 32'h18)});
        tbl.push_back('{"lw_stored", 32'h0080A103, 32'h14, 1'b0, 1'b0, 5'd0, 32'd0,
            mk(1, 2'b01, 0, 0, 0, 3'b000, 1, 32'h1234, 0, 8, 1, 8, 2, 32'h14, 32'h18)});
        tbl.push_back('{"x0_write", 32'h000001B3, 32'h18, 1'b0, 1'b1, 5'd0, 32'hDEAD,
            mk(1, 2'b00, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 3, 32'h18, 32'h1C)});
        tbl.push_back('{"x0_read", 32'h000001B3, 32'h18, 1'b0, 1'b0, 5'd0, 32'd0,
            mk(1, 2'b00, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 3, 32'h18, 32'h1C)});
        tbl.push_back('{"sw", 32'h0020A623, 32'h20, 1'b0, 1'b0, 5'd0, 32'd0,
            mk(0, 2'b00, 1, 0, 0, 3'b000, 1, 32'h1234, 0, 12, 1, 2, 12, 32'h20, 32'h24)});
        tbl.push_back('{"beq_neg", 32'hFE000CE3, 32'h40, 1'b0, 1'b0, 5'd0, 32'd0,
            mk(0, 2'b00, 0, 0, 1, 3'b001, 0, 0, 0, 32'hFFFFFFF8, 0, 0, 25, 32'h40, 32'h44)});
        tbl.push_back('{"illegal_wrap", 32'h0000007F, 32'hFFFFFFFC, 1'b0, 1'b0, 5'd0, 32'd0,
            mk(0, 2'b00, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 32'hFFFFFFFC, 32'h0)});
        tbl.push_back('{"flush_jal", 32'h008000EF, 32'h50, 1'b1, 1'b1, 5'd5, 32'hCAFE,
            mk(0, 2'b00, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0)});
        tbl.push_back('{"read_x5", 32'h00028333, 32'h50, 1'b0, 1'b0, 5'd0, 32'd0,
            mk(1, 2'b00, 0, 0, 0, 3'b000, 0, 32'hCAFE, 0, 0, 5, 0, 6, 32'h50, 32'h54)});
        tbl.push_back('{"jal", 32'h008000EF, 32'h60, 1'b0, 1'b0, 5'd0, 32'd0,
            mk(1, 2'b10, 0, 1, 0, 3'b000, 0, 0, 0, 8, 0, 8, 1, 32'h60, 32'h64)});
        tbl.push_back('{"ori_neg", 32'hFFF0E393, 32'h70, 1'b0, 1'b0, 5'd0, 32'd0,
            mk(1, 2'b00, 0, 0, 0, 3'b011, 1, 32'h1234, 0, 32'hFFFFFFFF, 1, 31, 7, 32'h70, 32'h74)});
        tbl.push_back('{"sub", 32'h40508433, 32'h80, 1'b0, 1'b0, 5'd0, 32'd0,
            mk(1, 2'b00, 0, 0, 0, 3'b001, 0, 32'h1234, 32'hCAFE, 32'h405, 1, 5, 8, 32'h80, 32'h84)});

        foreach (tbl[i]) begin
            apply(tbl[i].instr, tbl[i].pc, tbl[i].flush, tbl[i].we, tbl[i].rdw, tbl[i].resw, want);
            check(tbl[i].name, act, tbl[i].exp);
        end

        // Asynchronous reset mid-cycle, no clock edge between assert and check
        #2;
        rst = 1'b0;
        #1;
        check("async_reset", act, rst_val);
        foreach (mregs[i]) mregs[i] = 32'd0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        apply(32'h005084B3, 32'h90, 1'b0, 1'b0, 5'd0, 32'd0, want);
        check("post_reset_regs", act,
              mk(1, 2'b00, 0, 0, 0, 3'b000, 0, 0, 0, 5, 1, 5, 9, 32'h90, 32'h94));

        ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h00};
        for (int n = 0; n < 400; n++) begin
            logic [31:0] ins;
            logic [6:0]  op;
            logic [4:0]  rdw;
            ins = $urandom;
            op  = ops[$urandom_range(0, 6)];
            if (op == 7'h00) op = 7'($urandom);
            ins[6:0] = op;
            rdw = ($urandom_range(0, 1) == 0) ? ins[19:15] : 5'($urandom);
            apply(ins, $urandom, ($urandom_range(0, 7) == 0), 1'($urandom), rdw, $urandom, want);
            check("random", act, want);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
